// File: rtl/game_pkg.sv
// Game-wide types and default tuning for the player shot and related controllers.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } shot_state_t;

    localparam int SHOT_SPEED_DEF     = 8;
    localparam int SHOT_START_Y_DEF   = 700;
    localparam int COOLDOWN_TICKS_DEF = 10;

endpackage

// File: rtl/vga_pkg.sv
// Display geometry shared by the video timing, sprite and game controllers.
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

endpackage

// File: rtl/player_shot_ctl_if.sv
// Signal bundle between the game environment and the player shot controller.
interface player_shot_ctl_if;
    import game_pkg::*;

    // No backpressure: button_fire and hit are sampled every clock, shot_* are
    // registered and shot_xpos/shot_ypos are only meaningful while shot_active is high.
    logic        button_fire;
    logic [11:0] player_xpos;
    logic        hit;
    logic        shot_active;
    logic [11:0] shot_xpos;
    logic [11:0] shot_ypos;
    logic        shot_fired;
    shot_state_t dbg_state;

    modport master (
        output button_fire, player_xpos, hit,
        input  shot_active, shot_xpos, shot_ypos, shot_fired, dbg_state
    );

    modport slave (
        input  button_fire, player_xpos, hit,
        output shot_active, shot_xpos, shot_ypos, shot_fired, dbg_state
    );

endinterface

// File: rtl/tick_gen.sv
// Free-running divider: tick is high for one clock every DELAY+1 clocks.
module tick_gen #(
    parameter int DELAY = 650000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (DELAY < 1) ? 1 : $clog2(DELAY + 1);
    localparam logic [W-1:0] TERM = W'(DELAY);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == TERM);

endmodule

// File: rtl/player_shot_ctl.sv
// Player laser shot sequencer: launch on fire edge, climb on ticks, retire on hit
// or top of screen, then hold off for a cooldown before the next launch.
module player_shot_ctl
    import game_pkg::*;
    import vga_pkg::*;
#(
    parameter int PLAYER_WIDTH   = 32,
    parameter int SHOT_SPEED     = game_pkg::SHOT_SPEED_DEF,
    parameter int SHOT_DELAY     = 650000,
    parameter int SHOT_START_Y   = game_pkg::SHOT_START_Y_DEF,
    parameter int COOLDOWN_TICKS = game_pkg::COOLDOWN_TICKS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    player_shot_ctl_if.slave  bus
);

    localparam logic [11:0] START_Y = 12'(SHOT_START_Y);
    localparam logic [11:0] SPEED   = 12'(SHOT_SPEED);
    localparam logic [11:0] X_MAX   = 12'(HOR_PIXELS - 1);
    localparam logic [12:0] HALF_W  = 13'(PLAYER_WIDTH / 2);
    localparam logic [15:0] CD_LOAD = 16'(COOLDOWN_TICKS);

    shot_state_t state, state_nxt;
    logic        tick;
    logic        fire_q;
    logic        fire_rise;
    logic        active_q, active_nxt;
    logic        fired_q, fired_nxt;
    logic [11:0] xpos_q, xpos_nxt;
    logic [11:0] ypos_q, ypos_nxt;
    logic [15:0] cd_cnt, cd_nxt;
    logic [12:0] launch_x;
    logic [11:0] launch_x_clamped;

    tick_gen #(.DELAY(SHOT_DELAY)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign fire_rise = bus.button_fire & ~fire_q;

    // Sum in 13 bits so a player near the right edge clamps instead of wrapping.
    assign launch_x         = {1'b0, bus.player_xpos} + HALF_W;
    assign launch_x_clamped = (launch_x > {1'b0, X_MAX}) ? X_MAX : launch_x[11:0];

    always_comb begin
        state_nxt  = state;
        active_nxt = active_q;
        fired_nxt  = 1'b0;
        xpos_nxt   = xpos_q;
        ypos_nxt   = ypos_q;
        cd_nxt     = cd_cnt;
        case (state)
            IDLE: begin
                if (fire_rise) begin
                    state_nxt  = FLYING;
                    active_nxt = 1'b1;
                    fired_nxt  = 1'b1;
                    xpos_nxt   = launch_x_clamped;
                    ypos_nxt   = START_Y;
                end
            end
            FLYING: begin
                if (bus.hit) begin
                    state_nxt  = COOLDOWN;
                    active_nxt = 1'b0;
                    cd_nxt     = CD_LOAD;
                end else if (tick) begin
                    if (ypos_q < SPEED) begin
                        state_nxt  = COOLDOWN;
                        active_nxt = 1'b0;
                        cd_nxt     = CD_LOAD;
                    end else begin
                        ypos_nxt = ypos_q - SPEED;
                    end
                end
            end
            COOLDOWN: begin
                if (COOLDOWN_TICKS == 0) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (cd_cnt <= 16'd1) begin
                        state_nxt = IDLE;
                    end else begin
                        cd_nxt = cd_cnt - 16'd1;
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                active_nxt = 1'b0;
            end
        endcase
    end

    // fire_q resets high so a button held through reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fire_q   <= 1'b1;
            active_q <= 1'b0;
            fired_q  <= 1'b0;
            xpos_q   <= '0;
            ypos_q   <= START_Y;
            cd_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            fire_q   <= bus.button_fire;
            active_q <= active_nxt;
            fired_q  <= fired_nxt;
            xpos_q   <= xpos_nxt;
            ypos_q   <= ypos_nxt;
            cd_cnt   <= cd_nxt;
        end
    end

    assign bus.shot_active = active_q;
    assign bus.shot_fired  = fired_q;
    assign bus.shot_xpos   = xpos_q;
    assign bus.shot_ypos   = ypos_q;
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_player_shot_ctl.sv
// Bench for player_shot_ctl: directed scenarios plus random play, checked every
// cycle against a behavioural model and pinned by hand-computed values.
module tb_player_shot_ctl;
    import game_pkg::*;
    import vga_pkg::*;

    localparam int PW    = 32;
    localparam int SPD   = 8;
    localparam int DLY   = 3;
    localparam int STY   = 40;
    localparam int CDT   = 2;
    localparam int W     = 28;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    player_shot_ctl_if bus();

    player_shot_ctl #(
        .PLAYER_WIDTH   (PW),
        .SHOT_SPEED     (SPD),
        .SHOT_DELAY     (DLY),
        .SHOT_START_Y   (STY),
        .COOLDOWN_TICKS (CDT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- behavioural model ----------------
    shot_state_t m_state  = IDLE;
    logic        m_active = 1'b0;
    logic        m_fired  = 1'b0;
    int          m_x      = 0;
    int          m_y      = STY;
    int          m_cd     = 0;
    logic        m_prev   = 1'b1;
    int          m_edges  = 0;
    logic        m_tick_last = 1'b0;

    logic [W-1:0] exp_q[$];

    task automatic model_reset();
        m_state = IDLE; m_active = 1'b0; m_fired = 1'b0;
        m_x = 0; m_y = STY; m_cd = 0; m_prev = 1'b1;
        m_edges = 0; m_tick_last = 1'b0;
    endtask

    always @(negedge rst_n) begin
        model_reset();
        exp_q.delete();
    end

    always @(posedge clk) begin
        logic tick;
        logic rise;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_edges++;
            tick = (m_edges % (DLY + 1)) == 0;
            rise = bus.button_fire && !m_prev;
            m_prev = bus.button_fire;
            m_fired = 1'b0;
            case (m_state)
                IDLE: if (rise) begin
                    m_state = FLYING; m_active = 1'b1; m_fired = 1'b1;
                    m_y = STY;
                    m_x = (int'(bus.player_xpos) + PW / 2 > HOR_PIXELS - 1) ?
                          HOR_PIXELS - 1 : int'(bus.player_xpos) + PW / 2;
                end
                FLYING: begin
                    if (bus.hit || (tick && m_y < SPD)) begin
                        m_state = COOLDOWN; m_active = 1'b0; m_cd = CDT;
                    end else if (tick) begin
                        m_y = m_y - SPD;
                    end
                end
                default: begin
                    if (CDT == 0) m_state = IDLE;
                    else if (tick) begin
                        m_cd--;
                        if (m_cd <= 0) m_state = IDLE;
                    end
                end
            endcase
            m_tick_last = tick;
        end
        exp_q.push_back({m_state, m_active, m_fired, 12'(m_x), 12'(m_y)});
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.dbg_state, bus.shot_active, bus.shot_fired, bus.shot_xpos, bus.shot_ypos};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle t=%0t {st,act,fired,x,y} got=%0d,%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d,%0d",
                         $time, a[27:26], a[25], a[24], a[23:12], a[11:0],
                         e[27:26], e[25], e[24], e[23:12], e[11:0]);
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            cyc(1);
            n++;
        end while (!m_tick_last && n < 20);
        if (!m_tick_last) timeout("wait_tick");
    endtask

    task automatic wait_state(shot_state_t s);
        int n = 0;
        while (m_state != s && n < 300) begin
            cyc(1);
            n++;
        end
        if (m_state != s) timeout("wait_state");
    endtask

    task automatic launch(logic [11:0] px);
        bus.button_fire = 1'b0;
        cyc(1);
        bus.player_xpos = px;
        bus.button_fire = 1'b1;
        cyc(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int ys[5] = '{32, 24, 16, 8, 0};
        int n;

        // 1: button held through reset release must not launch
        rst_n = 1'b0;
        bus.button_fire = 1'b1;
        bus.hit = 1'b0;
        bus.player_xpos = 12'd0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        at_neg();
        chk("rst_active", 32'(bus.shot_active), 0);
        chk("rst_ypos", 32'(bus.shot_ypos), STY);
        chk("rst_fired", 32'(bus.shot_fired), 0);
        cyc(10);
        at_neg();
        chk("held_no_fire", 32'(bus.shot_active), 0);

        // 2: full flight off the top of the screen
        launch(12'd100);
        at_neg();
        chk("launch_active", 32'(bus.shot_active), 1);
        chk("launch_x", 32'(bus.shot_xpos), 116);
        chk("launch_y", 32'(bus.shot_ypos), 40);
        chk("launch_fired", 32'(bus.shot_fired), 1);
        bus.player_xpos = 12'd500;
        foreach (ys[i]) begin
            wait_tick();
            at_neg();
            chk("step_y", 32'(bus.shot_ypos), 32'(ys[i]));
        end
        chk("fired_one_cycle", 32'(bus.shot_fired), 0);
        chk("x_fixed", 32'(bus.shot_xpos), 116);
        wait_tick();
        at_neg();
        chk("offtop_active", 32'(bus.shot_active), 0);
        chk("offtop_state", 32'(bus.dbg_state), 32'(COOLDOWN));
        wait_tick();
        wait_tick();
        at_neg();
        chk("cd_done", 32'(bus.dbg_state), 32'(IDLE));

        // 3: hit coincident with a tick at y=24
        launch(12'd300);
        n = 0;
        while (!(m_state == FLYING && m_y == 24 && ((m_edges + 1) % (DLY + 1)) == 0) && n < 200) begin
            cyc(1);
            n++;
        end
        if (n >= 200) timeout("hit_align");
        bus.hit = 1'b1;
        cyc(1);
        bus.hit = 1'b0;
        at_neg();
        chk("hit_active", 32'(bus.shot_active), 0);
        chk("hit_y", 32'(bus.shot_ypos), 24);
        wait_tick();
        at_neg();
        chk("hit_cd1", 32'(bus.dbg_state), 32'(COOLDOWN));
        wait_tick();
        at_neg();
        chk("hit_cd2", 32'(bus.dbg_state), 32'(IDLE));

        // 4: edges in FLYING / COOLDOWN ignored, held button no refire
        launch(12'd50);
        bus.button_fire = 1'b0;
        cyc(1);
        bus.button_fire = 1'b1;
        cyc(1);
        at_neg();
        chk("fly_edge_state", 32'(bus.dbg_state), 32'(FLYING));
        chk("fly_edge_fired", 32'(bus.shot_fired), 0);
        wait_state(COOLDOWN);
        bus.button_fire = 1'b0;
        cyc(1);
        bus.button_fire = 1'b1;
        cyc(1);
        at_neg();
        chk("cd_edge_active", 32'(bus.shot_active), 0);
        wait_state(IDLE);
        cyc(6);
        at_neg();
        chk("held_cd_active", 32'(bus.shot_active), 0);
        launch(12'd60);
        at_neg();
        chk("refire_active", 32'(bus.shot_active), 1);
        chk("refire_x", 32'(bus.shot_xpos), 76);

        // 5: clamp at the right edge
        wait_state(IDLE);
        launch(12'(HOR_PIXELS - 4));
        at_neg();
        chk("clamp_x", 32'(bus.shot_xpos), 32'(HOR_PIXELS - 1));

        // 6: asynchronous reset mid-flight
        cyc(5);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_active", 32'(bus.shot_active), 0);
        chk("async_y", 32'(bus.shot_ypos), STY);
        chk("async_state", 32'(bus.dbg_state), 32'(IDLE));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        launch(12'd200);
        at_neg();
        chk("post_rst_x", 32'(bus.shot_xpos), 216);
        chk("post_rst_active", 32'(bus.shot_active), 1);

        // random play
        for (int i = 0; i < 1500; i++) begin
            cyc(1);
            if ($urandom_range(0, 7) == 0) bus.button_fire = ~bus.button_fire;
            bus.hit = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) bus.player_xpos = 12'($urandom_range(0, 4095));
        end
        bus.hit = 1'b0;
        cyc(2);
        at_neg();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_shot_ctl.md
# player_shot_ctl

Sequences the player's single laser shot. It launches a shot from the player's current x position on a fire-button rising edge, then steps the shot upward on a periodic movement tick. The shot retires on a collision hit or when it leaves the top of the screen, and a cooldown is enforced before the next launch. It sits beside the player movement controller and feeds shot position to the sprite renderer and the collision logic.

## Interface
- PLAYER_WIDTH, 32: player sprite width in pixels; sets the launch x offset.
- SHOT_SPEED, 8: pixels moved upward per tick.
- SHOT_DELAY, 650000: tick divider terminal count; tick period is SHOT_DELAY+1 clocks.
- SHOT_START_Y, 700: launch y (top of player sprite).
- COOLDOWN_TICKS, 10: ticks spent in COOLDOWN after the shot retires.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- button_fire  in  1  fire button, already synchronised and debounced, level.
- player_xpos  in  12  current player x (left edge).
- hit  in  1  collision pulse from hit detection; meaningful only in FLYING.
- shot_active  out  1  shot is on screen.
- shot_xpos  out  12  shot x, constant during a flight.
- shot_ypos  out  12  shot y.
- shot_fired  out  1  one-cycle launch pulse, used for sound.

## Operation
- **Tick divider**
  - Free-running counter 0..SHOT_DELAY.
  - `tick` is high for one cycle when the counter equals SHOT_DELAY; the counter wraps to 0 on the same edge.
  - Firing never resets the divider, so the first step after launch occurs 1..SHOT_DELAY+1 cycles later.
- **Edge detect**
  - `fire_rise = button_fire & ~fire_q`, where `fire_q` holds the previous-cycle value of button_fire.
  - `fire_q` resets to 1, so a button held through reset release does not fire.
- **FSM states:** IDLE, FLYING, COOLDOWN.
- **IDLE**
  - On fire_rise, go to FLYING.
  - Load shot_ypos = SHOT_START_Y.
  - Load shot_xpos = player_xpos + PLAYER_WIDTH/2, computed 13-bit and clamped to HOR_PIXELS-1.
  - Set shot_active = 1 and shot_fired = 1.
- **FLYING**
  - hit has priority. If hit, go to COOLDOWN, clear shot_active, leave shot_ypos unchanged.
  - Else, on tick:
    - if shot_ypos < SHOT_SPEED, go to COOLDOWN and clear shot_active (off-screen);
    - otherwise shot_ypos -= SHOT_SPEED.
  - shot_ypos never underflows.
- **COOLDOWN**
  - Load cd_cnt = COOLDOWN_TICKS on entry.
  - Each tick: if cd_cnt <= 1, go to IDLE; else decrement cd_cnt.
  - If COOLDOWN_TICKS = 0, go to IDLE on the next clock regardless of tick.
- **Ignored inputs**
  - fire_rise in FLYING or COOLDOWN is discarded; nothing is queued.
  - Holding the button across COOLDOWN does not auto-fire; a new rising edge is required.
  - hit outside FLYING is ignored.
- **Retire state:** shot_xpos and shot_ypos keep their last values after retire; consumers qualify them with shot_active.

## Timing
- **Reset values** (immediately on rst_n low, no clock needed):
  - state IDLE, shot_active 0, shot_fired 0;
  - shot_xpos 0, shot_ypos SHOT_START_Y;
  - divider 0, cd_cnt 0, fire_q 1.
- All outputs are registered.
- **Launch latency:** button_fire rises before edge k, so shot_active, shot_fired and the positions are valid after edge k. shot_fired drops after edge k+1.
- **Retire latency:** one clock from the hit cycle or the terminal tick.
- **Simultaneous hit and tick:** the hit is taken and no position step occurs.
- **player_xpos** is sampled only at launch; later changes do not move the shot.
- **Reset release:** rst_n is released synchronously by the external reset synchroniser. The first tick after release occurs SHOT_DELAY+1 clocks later.

## Structure
- shot_state_t (IDLE, FLYING, COOLDOWN) goes in game_pkg. game_pkg also holds the SHOT_SPEED, SHOT_START_Y and COOLDOWN_TICKS defaults.
- HOR_PIXELS comes from vga_pkg.
- One sub-module, `tick_gen` (parameter DELAY, ports clk, rst_n, tick). It is the tick divider, reused later by the alien march and bomb controllers.

## Test plan
Bench parameters: SHOT_DELAY=3 (tick every 4 clocks), SHOT_SPEED=8, SHOT_START_Y=40, COOLDOWN_TICKS=2.

1. Reset with button_fire=1 held, then release rst_n -> shot_active=0, shot_ypos=40, shot_fired=0, and no launch while the button stays high.
2. player_xpos=100, fire edge -> next clock shot_active=1, shot_xpos=116, shot_ypos=40, shot_fired high exactly 1 cycle. Successive ticks give ypos 32, 24, 16, 8, 0. The next tick clears shot_active. Two further ticks return the FSM to IDLE.
3. During flight at ypos=24, assert hit in the same cycle as tick -> next clock shot_active=0 and shot_ypos stays 24. COOLDOWN then lasts 2 ticks.
4. Fire edges during FLYING and during COOLDOWN -> ignored. Button held across COOLDOWN -> no refire. A fresh edge in IDLE -> launch.
5. player_xpos = HOR_PIXELS-4 at fire -> shot_xpos = HOR_PIXELS-1 (clamped).
6. Drop rst_n asynchronously mid-flight, between clock edges -> shot_active=0 and shot_ypos=40 immediately, without a clock edge. Operation is normal after release.
